memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 64, giving the number of 32-bit data-memory words; DEPTH is a power of two, 4 to 1024.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have inputs RegWriteE, MemtoRegE and MemWriteE, 1 bit each: execute-stage control bits.
REQ-005 SHALL have inputs ALUOutE [31:0] (address/result), WriteDataE [31:0] (store data) and WriteRegE [4:0] (destination register).
REQ-006 SHALL have inputs StallM, 1 bit (hold the EX/MEM register), and FlushM, 1 bit (load a bubble).
REQ-007 SHALL have outputs RD [31:0], ALUOutM [31:0], RegWriteM (1 bit), MemtoRegM (1 bit) and WriteRegM [4:0], which feed the write-back stage directly.
REQ-008 SHALL have output MemWriteM, 1 bit: the registered store strobe, for hazard visibility.

Function
REQ-009 SHALL register every E input into its M counterpart on each rising CLK edge (EX/MEM register, latency 1 cycle).
REQ-010 SHALL apply load priority per edge: FlushM, then StallM, then normal load.
REQ-011 On FlushM=1 SHALL clear RegWriteM, MemtoRegM and MemWriteM to 0; the data fields may load or hold.
REQ-012 When StallM=1 and FlushM=0, every M register SHALL hold its value.
REQ-013 SHALL index word storage by ALUOutM[log2(DEPTH)+1:2], so addresses wrap modulo DEPTH words.
REQ-014 SHALL ignore ALUOutM[1:0] in word mode.
REQ-015 SHALL perform a store on a rising edge when MemWriteM=1 and StallM=0: mem[index] <= WriteDataM.
REQ-016 A stalled store SHALL write exactly once, on the first unstalled edge.
REQ-017 RD SHALL be a combinational read of mem[index] for the current ALUOutM, regardless of MemtoRegM.
REQ-018 A load that immediately follows a store to the same word SHALL read the newly written data.
REQ-019 A store to a word SHALL change RD combinationally in the same cycle only after the write edge, never before it.
REQ-020 Simultaneous FlushM=1 and StallM=1 SHALL behave as a flush; a store pending in M on that edge still writes only if StallM=0.

Reset
REQ-021 While Reset=0, all M registers SHALL be 0 (ALUOutM=0, WriteRegM=0, RegWriteM=MemtoRegM=MemWriteM=0).
REQ-022 While Reset=0, all DEPTH memory words SHALL clear to 0, so RD=0; the clear is asynchronous and independent of CLK.
REQ-023 Reset asserted mid-store SHALL abort the write; memory SHALL read 0 after reset.
REQ-024 After Reset deasserts, the first rising edge SHALL load normally.

Configuration
REQ-025 Macro MEM_BYTE_EN defined: SHALL add input ByteE (1 bit) and register ByteM.
REQ-026 With MEM_BYTE_EN, a store with ByteM=1 SHALL write WriteDataM[7:0] into byte lane ALUOutM[1:0] only, leaving the other lanes unchanged.
REQ-027 With MEM_BYTE_EN, a load with ByteM=1 SHALL return on RD the sign-extended byte from lane ALUOutM[1:0].
REQ-028 With MEM_BYTE_EN, FlushM SHALL clear ByteM.
REQ-029 Macro MEM_BYTE_EN undefined: port ByteE SHALL be absent and all accesses SHALL be word-only.

Verification
REQ-030 Reset pulse low with memory preloaded -> all outputs 0 and RD=0 at every address.
REQ-031 Store 0xDEADBEEF to address 0x10, then load 0x10 -> RD=0xDEADBEEF, MemtoRegM=1 the cycle after load issue.
REQ-032 Store 0x11111111 to address 0x100 with DEPTH=64 -> word 0 reads 0x11111111 (wrap-around).
REQ-033 Store held in M with StallM=1 for 3 cycles -> memory unchanged for 3 cycles; single write on release; M registers unchanged while stalled.
REQ-034 FlushM=1 with MemWriteE=1, RegWriteE=1 -> next cycle MemWriteM=0 and RegWriteM=0; memory unchanged.
REQ-035 With MEM_BYTE_EN: word 0x00000000 at address 0x20, store byte 0x80 to address 0x22 -> word reads 0x00800000; byte load of 0x22 gives RD=0xFFFFFF80.

Source files
------------

// File: rtl/memory_stage.sv
// Memory stage: EX/MEM pipeline register plus DEPTH-word data memory with combinational read.
// Optional byte access (store lane, sign-extended load) is enabled by defining MEM_BYTE_EN.
module memory_stage #(
  parameter int DEPTH = 64
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
`ifdef MEM_BYTE_EN
  input  logic        ByteE,
`endif
  input  logic        StallM,
  input  logic        FlushM,
  output logic [31:0] RD,
  output logic [31:0] ALUOutM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic [4:0]  WriteRegM,
  output logic        MemWriteM
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   writeData_r;
  logic [31:0]   mem_r [DEPTH];
  logic [AW-1:0] memIndex_s;
  logic [31:0]   storeWord_s;
  logic [31:0]   readWord_s;
  logic          storeEn_s;
`ifdef MEM_BYTE_EN
  logic          byteM_r;
`endif

  assign memIndex_s = ALUOutM[AW+1:2];
  assign storeEn_s  = MemWriteM & ~StallM;
  assign readWord_s = mem_r[memIndex_s];

  // EX/MEM register: flush clears control bits but still loads data, stall holds everything
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ALUOutM     <= 32'd0;
      writeData_r <= 32'd0;
      WriteRegM   <= 5'd0;
      RegWriteM   <= 1'b0;
      MemtoRegM   <= 1'b0;
      MemWriteM   <= 1'b0;
`ifdef MEM_BYTE_EN
      byteM_r     <= 1'b0;
`endif
    end else if (FlushM) begin
      ALUOutM     <= ALUOutE;
      writeData_r <= WriteDataE;
      WriteRegM   <= WriteRegE;
      RegWriteM   <= 1'b0;
      MemtoRegM   <= 1'b0;
      MemWriteM   <= 1'b0;
`ifdef MEM_BYTE_EN
      byteM_r     <= 1'b0;
`endif
    end else if (!StallM) begin
      ALUOutM     <= ALUOutE;
      writeData_r <= WriteDataE;
      WriteRegM   <= WriteRegE;
      RegWriteM   <= RegWriteE;
      MemtoRegM   <= MemtoRegE;
      MemWriteM   <= MemWriteE;
`ifdef MEM_BYTE_EN
      byteM_r     <= ByteE;
`endif
    end
  end

  // Store data: whole word, or one byte lane merged into the current word
  always_comb begin
    storeWord_s = writeData_r;
`ifdef MEM_BYTE_EN
    if (byteM_r) begin
      storeWord_s = readWord_s;
      storeWord_s[{ALUOutM[1:0], 3'b000} +: 8] = writeData_r[7:0];
    end else begin
      storeWord_s = writeData_r;
    end
`endif
  end

  // Data memory: asynchronous clear; a stalled store waits and writes on the first unstalled edge
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'd0;
      end
    end else if (storeEn_s) begin
      mem_r[memIndex_s] <= storeWord_s;
    end
  end

  // Combinational read of the addressed word, independent of MemtoRegM
  always_comb begin
    RD = readWord_s;
`ifdef MEM_BYTE_EN
    if (byteM_r) begin
      RD = {{24{readWord_s[{ALUOutM[1:0], 3'b111}]}}, readWord_s[{ALUOutM[1:0], 3'b000} +: 8]};
    end else begin
      RD = readWord_s;
    end
`endif
  end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a driver updates a behavioural model and queues expected
// outputs per edge; a monitor pops and compares after every rising edge.
module tb_memory_stage;

  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic        CLK;
  logic        Reset;
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic [31:0] ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE;
  logic        ByteE;
  logic        StallM, FlushM;
  logic [31:0] RD, ALUOutM;
  logic        RegWriteM, MemtoRegM, MemWriteM;
  logic [4:0]  WriteRegM;

  memory_stage #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .Reset(Reset),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
`ifdef MEM_BYTE_EN
    .ByteE(ByteE),
`endif
    .StallM(StallM), .FlushM(FlushM),
    .RD(RD), .ALUOutM(ALUOutM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegM(WriteRegM), .MemWriteM(MemWriteM)
  );

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        rw, m2r, mw;
    logic [31:0] rd;
    bit          known;
    int          id;
  } exp_t;

  exp_t        expQ[$];
  int          totalChecks = 0;
  int          passChecks  = 0;
  int          stepId      = 0;

  // behavioural reference: word array plus the instruction currently sitting in M
  logic [31:0] model [DEPTH];
  logic [31:0] mAlu, mWd;
  logic [4:0]  mWr;
  logic        mRw, mM2r, mMw, mByte;
  bit          mKnown;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) passChecks++;
    else $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
  endtask

  function automatic logic [31:0] readModel(input logic [31:0] a, input logic bt);
    logic [31:0] w;
    logic [7:0]  b;
    w = model[int'(a[AW+1:2])];
    b = w[8*int'(a[1:0]) +: 8];
    return bt ? {{24{b[7]}}, b} : w;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
    mAlu = 32'd0; mWd = 32'd0; mWr = 5'd0;
    mRw = 1'b0; mM2r = 1'b0; mMw = 1'b0; mByte = 1'b0; mKnown = 1'b1;
  endtask

  task automatic pushExp();
    exp_t e;
    e.alu = mAlu; e.wr = mWr; e.rw = mRw; e.m2r = mM2r; e.mw = mMw;
    e.rd = readModel(mAlu, mByte); e.known = mKnown; e.id = stepId;
    expQ.push_back(e);
  endtask

  // one cycle of stimulus; also releases reset if it is held
  task automatic step(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                      input logic rw, input logic m2r, input logic mw, input logic bt,
                      input logic stall, input logic flush);
    logic bsel;
    @(negedge CLK);
    stepId++;
    Reset = 1'b1;
    ALUOutE = alu; WriteDataE = wd; WriteRegE = wr;
    RegWriteE = rw; MemtoRegE = m2r; MemWriteE = mw; ByteE = bt;
    StallM = stall; FlushM = flush;
`ifdef MEM_BYTE_EN
    bsel = bt;
`else
    bsel = 1'b0;
`endif
    if (mMw && !stall) begin
      if (mByte) model[int'(mAlu[AW+1:2])][8*int'(mAlu[1:0]) +: 8] = mWd[7:0];
      else       model[int'(mAlu[AW+1:2])] = mWd;
    end
    if (flush) begin
      mRw = 1'b0; mM2r = 1'b0; mMw = 1'b0; mByte = 1'b0; mKnown = 1'b0;
    end else if (!stall) begin
      mAlu = alu; mWd = wd; mWr = wr; mRw = rw; mM2r = m2r; mMw = mw; mByte = bsel;
      mKnown = 1'b1;
    end
    pushExp();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    step(a, d, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] r);
    step(a, 32'd0, r, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // asserts reset mid-cycle, checks the asynchronous clear, and holds it across one edge
  task automatic pulseReset();
    @(negedge CLK);
    #2;
    Reset = 1'b0;
    #1;
    stepId++;
    chk("async_ALUOutM", stepId, ALUOutM, 32'd0);
    chk("async_RD", stepId, RD, 32'd0);
    chk("async_ctrl", stepId, {29'd0, RegWriteM, MemtoRegM, MemWriteM}, 32'd0);
    chk("async_WriteRegM", stepId, {27'd0, WriteRegM}, 32'd0);
    modelReset();
    pushExp();
  endtask

  // monitor: compare DUT against the oldest queued expectation after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("RegWriteM", e.id, {31'd0, RegWriteM}, {31'd0, e.rw});
        chk("MemtoRegM", e.id, {31'd0, MemtoRegM}, {31'd0, e.m2r});
        chk("MemWriteM", e.id, {31'd0, MemWriteM}, {31'd0, e.mw});
        if (e.known) begin
          chk("ALUOutM", e.id, ALUOutM, e.alu);
          chk("WriteRegM", e.id, {27'd0, WriteRegM}, {27'd0, e.wr});
          chk("RD", e.id, RD, e.rd);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, d, mask;
    logic        st, fl;
    Reset = 1'b0;
    RegWriteE = 1'b0; MemtoRegE = 1'b0; MemWriteE = 1'b0;
    ALUOutE = 32'd0; WriteDataE = 32'd0; WriteRegE = 5'd0; ByteE = 1'b0;
    StallM = 1'b0; FlushM = 1'b0;
    modelReset();
    repeat (2) @(negedge CLK);
    chk("reset_RD", 0, RD, 32'd0);
    chk("reset_ctrl", 0, {29'd0, RegWriteM, MemtoRegM, MemWriteM}, 32'd0);

    // store then load of the same word; first edge after reset loads the store
    store(32'h10, 32'hDEADBEEF);
    load(32'h10, 5'd7);
    load(32'h13, 5'd8);
    // wrap-around: byte address 0x100 is word 0 for 64 words
    store(32'h100, 32'h11111111);
    load(32'h0, 5'd1);
    // stalled store: memory unchanged for 3 cycles, single write on release
    store(32'h40, 32'hA5A5_0001);
    repeat (3) step(32'h44, 32'h0BAD_0BAD, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    load(32'h40, 5'd2);
    // flush of a store and reg write
    step(32'h44, 32'hCAFE_F00D, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    load(32'h44, 5'd4);
    // flush together with stall behaves as flush; pending store is dropped
    store(32'h48, 32'h1234_5678);
    step(32'h4C, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    load(32'h48, 5'd5);
`ifdef MEM_BYTE_EN
    store(32'h20, 32'h0);
    step(32'h22, 32'h0000_0080, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    load(32'h20, 5'd6);
    step(32'h22, 32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      mask = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'h0000_03FF;
      a  = $urandom & mask;
      d  = $urandom;
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 9) == 0);
      step(a, d, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), st, fl);
    end

    // reset while a store sits in M: it must be aborted and all words read 0
    store(32'h8, 32'hFFFF_FFFF);
    pulseReset();
    for (int i = 0; i < DEPTH; i++) load(32'(i * 4), 5'd1);
    step(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge CLK);
    chk("queue_drained", stepId, 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
